// File: rtl/ps2_key_event_controller_if.sv
// Scancode input and game-control event bundle between PS2_Controller and the
// tic-tac-toe top level.
interface ps2_key_event_controller_if;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic       select;
  logic [4:0] key_held;
  logic [1:0] cursor_row;
  logic [1:0] cursor_col;
  logic [7:0] last_code;
  logic       protocol_error;

  modport master (
    output received_data, received_data_en,
    input  up, down, left, right, select, key_held,
    input  cursor_row, cursor_col, last_code, protocol_error
  );

  modport slave (
    input  received_data, received_data_en,
    output up, down, left, right, select, key_held,
    output cursor_row, cursor_col, last_code, protocol_error
  );
endinterface

// File: rtl/ps2_key_event_controller.sv
// Turns raw PS/2 scancode bytes into one-cycle move/select pulses, held-key
// levels and a 3x3 board cursor, handling F0/E0 prefixes and typematic repeat.
module ps2_key_event_controller #(
  parameter int unsigned PREFIX_TIMEOUT = 1000000,
  parameter int unsigned CURSOR_WRAP    = 0,
  parameter int unsigned REPEAT_EN      = 0
) (
  input logic                        CLOCK_50,
  input logic                        reset,
  ps2_key_event_controller_if.slave  bus
);

  localparam int unsigned CNT_W = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);
  localparam logic [7:0] BRK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE = 8'hE0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BREAK     = 2'd1,
    EXT       = 2'd2,
    EXT_BREAK = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       pulse_q, pulse_d;
  logic [4:0]       held_q, held_d;
  logic [1:0]       row_q, row_d;
  logic [1:0]       col_q, col_d;
  logic [7:0]       last_q, last_d;
  logic             err_q, err_d;
  logic [4:0]       make_key;
  logic [4:0]       brk_key;

  // One-hot key in {up,down,left,right,select} order; zero when unmapped.
  function automatic logic [4:0] map_std(input logic [7:0] code);
    case (code)
      8'h1D:        map_std = 5'b10000;
      8'h1B:        map_std = 5'b01000;
      8'h1C:        map_std = 5'b00100;
      8'h23:        map_std = 5'b00010;
      8'h22, 8'h5A: map_std = 5'b00001;
      default:      map_std = 5'b00000;
    endcase
  endfunction

  function automatic logic [4:0] map_ext(input logic [7:0] code);
    case (code)
      8'h75:   map_ext = 5'b10000;
      8'h72:   map_ext = 5'b01000;
      8'h6B:   map_ext = 5'b00100;
      8'h74:   map_ext = 5'b00010;
      8'h5A:   map_ext = 5'b00001;
      default: map_ext = 5'b00000;
    endcase
  endfunction

  function automatic logic [1:0] step_dec(input logic [1:0] pos);
    if (pos == 2'd0) step_dec = (CURSOR_WRAP != 0) ? 2'd2 : 2'd0;
    else             step_dec = pos - 2'd1;
  endfunction

  function automatic logic [1:0] step_inc(input logic [1:0] pos);
    if (pos >= 2'd2) step_inc = (CURSOR_WRAP != 0) ? 2'd0 : 2'd2;
    else             step_inc = pos + 2'd1;
  endfunction

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= '0;
      held_q  <= '0;
      row_q   <= 2'd1;
      col_q   <= 2'd1;
      last_q  <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      held_q  <= held_d;
      row_q   <= row_d;
      col_q   <= col_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pulse_d  = '0;
    held_d   = held_q;
    row_d    = row_q;
    col_d    = col_q;
    last_d   = last_q;
    err_d    = 1'b0;
    make_key = '0;
    brk_key  = '0;

    if (bus.received_data_en) begin
      last_d = bus.received_data;
      cnt_d  = '0;
      case (state_q)
        IDLE: begin
          if (bus.received_data == BRK_CODE)      state_d = BREAK;
          else if (bus.received_data == EXT_CODE) state_d = EXT;
          else                                    make_key = map_std(bus.received_data);
        end
        BREAK: begin
          state_d = IDLE;
          if (bus.received_data == BRK_CODE || bus.received_data == EXT_CODE) err_d = 1'b1;
          else brk_key = map_std(bus.received_data);
        end
        EXT: begin
          if (bus.received_data == BRK_CODE) begin
            state_d = EXT_BREAK;
          end else if (bus.received_data == EXT_CODE) begin
            err_d   = 1'b1;
          end else begin
            state_d  = IDLE;
            make_key = map_ext(bus.received_data);
          end
        end
        default: begin
          state_d = IDLE;
          if (bus.received_data == BRK_CODE || bus.received_data == EXT_CODE) err_d = 1'b1;
          else brk_key = map_ext(bus.received_data);
        end
      endcase
    end else if (state_q != IDLE) begin
      // Abandon a prefix that is never followed by its code byte.
      if (cnt_q == CNT_LAST) begin
        err_d   = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end

    // A make of an already-held key is a typematic repeat.
    if (make_key != 5'b00000) begin
      if ((held_q & make_key) == 5'b00000 || REPEAT_EN != 0) begin
        pulse_d = make_key;
        if (make_key[4]) row_d = step_dec(row_q);
        if (make_key[3]) row_d = step_inc(row_q);
        if (make_key[2]) col_d = step_dec(col_q);
        if (make_key[1]) col_d = step_inc(col_q);
      end
      held_d = held_q | make_key;
    end
    held_d = held_d & ~brk_key;
  end

  assign bus.up             = pulse_q[4];
  assign bus.down           = pulse_q[3];
  assign bus.left           = pulse_q[2];
  assign bus.right          = pulse_q[1];
  assign bus.select         = pulse_q[0];
  assign bus.key_held       = held_q;
  assign bus.cursor_row     = row_q;
  assign bus.cursor_col     = col_q;
  assign bus.last_code      = last_q;
  assign bus.protocol_error = err_q;

endmodule

// File: tb/tb_ps2_key_event_controller.sv
// Directed bench: one saturating and one wrapping instance driven with the
// same scancode streams, checked against hand-computed values.
module tb_ps2_key_event_controller;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  ps2_key_event_controller_if a_if ();
  ps2_key_event_controller_if b_if ();

  ps2_key_event_controller #(.PREFIX_TIMEOUT(16), .CURSOR_WRAP(0), .REPEAT_EN(0)) dut_a (
    .CLOCK_50(clk), .reset(reset), .bus(a_if.slave)
  );
  ps2_key_event_controller #(.PREFIX_TIMEOUT(16), .CURSOR_WRAP(1), .REPEAT_EN(0)) dut_b (
    .CLOCK_50(clk), .reset(reset), .bus(b_if.slave)
  );

  logic [4:0] pa;
  logic [4:0] pb;
  assign pa = {a_if.up, a_if.down, a_if.left, a_if.right, a_if.select};
  assign pb = {b_if.up, b_if.down, b_if.left, b_if.right, b_if.select};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    a_if.received_data_en = 1'b0;
    b_if.received_data_en = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Drive one strobe; returns #1 after the edge that consumed it.
  task automatic send(input logic [7:0] code);
    @(negedge clk);
    a_if.received_data = code;
    b_if.received_data = code;
    a_if.received_data_en = 1'b1;
    b_if.received_data_en = 1'b1;
    @(posedge clk);
    #1;
    a_if.received_data_en = 1'b0;
    b_if.received_data_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int exp_a[3] = '{2, 2, 2};
  int exp_b[3] = '{2, 0, 1};
  int seen;
  int up_count;

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    a_if.received_data = 8'h00;
    b_if.received_data = 8'h00;
    a_if.received_data_en = 1'b0;
    b_if.received_data_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    chk("rst_pulse", 32'(pa), 32'h0);
    chk("rst_held", 32'(a_if.key_held), 32'h0);
    chk("rst_row", 32'(a_if.cursor_row), 32'd1);
    chk("rst_col", 32'(a_if.cursor_col), 32'd1);
    chk("rst_last", 32'(a_if.last_code), 32'h00);
    chk("rst_err", 32'(a_if.protocol_error), 32'h0);

    // single W press
    send(8'h1D);
    chk("w_pulse", 32'(pa), 32'h10);
    chk("w_held", 32'(a_if.key_held), 32'h10);
    chk("w_row", 32'(a_if.cursor_row), 32'd0);
    chk("w_col", 32'(a_if.cursor_col), 32'd1);
    chk("w_last", 32'(a_if.last_code), 32'h1D);
    idle(1);
    chk("w_pulse_1cyc", 32'(pa), 32'h0);

    // typematic repeat suppressed, then break
    do_reset();
    up_count = 0;
    repeat (3) begin
      send(8'h1D);
      if (a_if.up) up_count++;
    end
    chk("rep_count", 32'(up_count), 32'd1);
    chk("rep_row", 32'(a_if.cursor_row), 32'd0);
    send(8'hF0);
    chk("rep_f0_held", 32'(a_if.key_held), 32'h10);
    chk("rep_f0_last", 32'(a_if.last_code), 32'hF0);
    send(8'h1D);
    chk("rep_brk_pulse", 32'(pa), 32'h0);
    chk("rep_brk_held", 32'(a_if.key_held), 32'h0);
    chk("rep_brk_row", 32'(a_if.cursor_row), 32'd0);

    // extended right arrow: saturate vs wrap
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(8'hE0);
      send(8'h74);
      chk("ext_r_pulse_a", 32'(pa), 32'h02);
      chk("ext_r_pulse_b", 32'(pb), 32'h02);
      chk("ext_r_col_a", 32'(a_if.cursor_col), 32'(exp_a[i]));
      chk("ext_r_col_b", 32'(b_if.cursor_col), 32'(exp_b[i]));
      send(8'hE0);
      send(8'hF0);
      send(8'h74);
      chk("ext_r_brk_held", 32'(a_if.key_held), 32'h0);
    end

    // break of unmapped code, then A
    do_reset();
    send(8'hF0);
    send(8'h12);
    chk("unm_pulse", 32'(pa), 32'h0);
    chk("unm_err", 32'(a_if.protocol_error), 32'h0);
    send(8'h1C);
    chk("unm_left", 32'(pa), 32'h04);
    chk("unm_col_a", 32'(a_if.cursor_col), 32'd0);
    chk("unm_col_b", 32'(b_if.cursor_col), 32'd0);

    // prefix timeout
    do_reset();
    send(8'hE0);
    seen = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (a_if.protocol_error) begin
        seen = c;
        break;
      end
    end
    chk("to_cycle", 32'(seen), 32'd16);
    idle(1);
    chk("to_err_1cyc", 32'(a_if.protocol_error), 32'h0);
    send(8'h75);
    chk("to_75_pulse", 32'(pa), 32'h0);
    chk("to_75_held", 32'(a_if.key_held), 32'h0);

    // strobe coincident with expiry wins
    do_reset();
    send(8'hE0);
    idle(15);
    send(8'h75);
    chk("exp_win_pulse", 32'(pa), 32'h10);
    chk("exp_win_err", 32'(a_if.protocol_error), 32'h0);
    chk("exp_win_row", 32'(a_if.cursor_row), 32'd0);

    // double F0 is malformed
    do_reset();
    send(8'hF0);
    send(8'hF0);
    chk("ff_err", 32'(a_if.protocol_error), 32'h1);
    send(8'h1D);
    chk("ff_then_w", 32'(pa), 32'h10);
    chk("ff_err_clr", 32'(a_if.protocol_error), 32'h0);

    // double E0 errors but stays extended
    do_reset();
    send(8'hE0);
    send(8'hE0);
    chk("ee_err", 32'(a_if.protocol_error), 32'h1);
    send(8'h72);
    chk("ee_down", 32'(pa), 32'h08);
    chk("ee_row", 32'(a_if.cursor_row), 32'd2);

    // reset mid-sequence discards prefix
    do_reset();
    send(8'hE0);
    do_reset();
    send(8'h5A);
    chk("mid_rst_sel", 32'(pa), 32'h01);
    chk("mid_rst_err", 32'(a_if.protocol_error), 32'h0);
    chk("mid_rst_row", 32'(a_if.cursor_row), 32'd1);
    chk("mid_rst_col", 32'(a_if.cursor_col), 32'd1);
    chk("mid_rst_held", 32'(a_if.key_held), 32'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
